// File: rtl/twin_uart_pkg.sv
// Shared types for the UART transmit arbiter: FSM states, one-hot grant codes
// and the width rule for its saturating counters.
package twin_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    WAIT_HI,
    WAIT_LO
  } arb_state_e;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_REQ0 = 2'b01;
  localparam logic [1:0] GRANT_REQ1 = 2'b10;

  // Counter width able to hold limit-1 with a spare bit for saturation.
  function automatic int cnt_width(input int limit);
    return $clog2(limit) + 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_arb2.sv
// Two-way round-robin pick: a lone valid wins, a tie goes to the requester
// that was not served last.
module rr_arb2
  import twin_uart_pkg::*;
(
  input  logic       valid0,
  input  logic       valid1,
  input  logic       last_grant,
  output logic [1:0] winner
);

  always_comb begin
    // NOTE: default first, so every path assigns winner and no latch is inferred.
    winner = GRANT_NONE;
    if (valid0 && valid1) begin
      winner = last_grant ? GRANT_REQ0 : GRANT_REQ1;
    end else if (valid0) begin
      winner = GRANT_REQ0;
    end else if (valid1) begin
      winner = GRANT_REQ1;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between two byte-stream requesters, granting
// whole packets round-robin and sequencing each byte through start/busy.
module uart_tx_arbiter
  import twin_uart_pkg::*;
#(
  parameter int PKT_TIMEOUT   = 50000,
  parameter int BUSY_ACK_WAIT = 4
) (
  input  logic       i_clk_50m,
  input  logic       rst_n,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  input  logic       req0_last,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  input  logic       req1_last,
  output logic       req1_ready,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_busy,
  output logic [1:0] o_grant,
  output logic       o_abort,
  output logic       o_err_noack
);

  localparam int TO_W  = cnt_width(PKT_TIMEOUT);
  localparam int ACK_W = cnt_width(BUSY_ACK_WAIT);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(PKT_TIMEOUT - 1);
  localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(BUSY_ACK_WAIT - 1);

  arb_state_e       state;
  logic             last_grant;  // 1: req1 was the last requester served
  logic             is_last;
  logic [TO_W-1:0]  to_cnt;
  logic [ACK_W-1:0] ack_cnt;
  logic [1:0]       winner;
  logic             sel_valid;
  logic             sel_last;
  logic [7:0]       sel_data;

  rr_arb2 u_rr_arb2 (
    .valid0     (req0_valid),
    .valid1     (req1_valid),
    .last_grant (last_grant),
    .winner     (winner)
  );

  assign sel_valid = o_grant[1] ? req1_valid : req0_valid;
  assign sel_data  = o_grant[1] ? req1_data  : req0_data;
  assign sel_last  = o_grant[1] ? req1_last  : req0_last;

  assign req0_ready = (state == LOAD) && o_grant[0] && req0_valid;
  assign req1_ready = (state == LOAD) && o_grant[1] && req1_valid;

  // Decoded from the state register so the pulse appears two cycles after
  // valid and is cut the moment reset asserts.
  assign tx_start = (state == START) && !tx_busy;

  always_ff @(posedge i_clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      o_grant     <= GRANT_NONE;
      last_grant  <= 1'b1;
      is_last     <= 1'b0;
      tx_data     <= '0;
      to_cnt      <= '0;
      ack_cnt     <= '0;
      o_abort     <= 1'b0;
      o_err_noack <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout, so every branch reads pre-edge state.
      o_abort <= 1'b0;
      case (state)
        IDLE: begin
          if (winner != GRANT_NONE) begin
            o_grant <= winner;
            to_cnt  <= '0;
            state   <= LOAD;
          end
        end
        LOAD: begin
          if (sel_valid) begin
            tx_data <= sel_data;
            is_last <= sel_last;
            to_cnt  <= '0;
            state   <= START;
          end else if (to_cnt == TO_LAST) begin
            o_abort    <= 1'b1;
            last_grant <= o_grant[1];
            o_grant    <= GRANT_NONE;
            state      <= IDLE;
          end else if (to_cnt != '1) begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        START: begin
          if (!tx_busy) begin
            ack_cnt <= '0;
            state   <= WAIT_HI;
          end
        end
        WAIT_HI: begin
          if (tx_busy) begin
            state <= WAIT_LO;
          end else if (ack_cnt == ACK_LAST) begin
            o_err_noack <= 1'b1;
            state       <= WAIT_LO;
          end else if (ack_cnt != '1) begin
            ack_cnt <= ack_cnt + 1'b1;
          end
        end
        WAIT_LO: begin
          if (!tx_busy) begin
            if (is_last) begin
              last_grant <= o_grant[1];
              o_grant    <= GRANT_NONE;
              state      <= IDLE;
            end else begin
              to_cnt <= '0;
              state  <= LOAD;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus randomized
// packets, scored against a packet-level model of the arbitration rules.
module tb_uart_tx_arbiter;
  import twin_uart_pkg::*;

  localparam int PKT_TO   = 100;
  localparam int ACK_WAIT = 4;
  localparam int BUSY_LEN = 10;

  logic       i_clk_50m = 1'b0;
  logic       rst_n;
  logic       req0_valid, req0_last, req0_ready;
  logic       req1_valid, req1_last, req1_ready;
  logic [7:0] req0_data, req1_data, tx_data;
  logic       tx_start, tx_busy, o_abort, o_err_noack;
  logic [1:0] o_grant;

  uart_tx_arbiter #(
    .PKT_TIMEOUT   (PKT_TO),
    .BUSY_ACK_WAIT (ACK_WAIT)
  ) dut (
    .i_clk_50m   (i_clk_50m),
    .rst_n       (rst_n),
    .req0_valid  (req0_valid),
    .req0_data   (req0_data),
    .req0_last   (req0_last),
    .req0_ready  (req0_ready),
    .req1_valid  (req1_valid),
    .req1_data   (req1_data),
    .req1_last   (req1_last),
    .req1_ready  (req1_ready),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .o_grant     (o_grant),
    .o_abort     (o_abort),
    .o_err_noack (o_err_noack)
  );

  always #10 i_clk_50m = ~i_clk_50m;

  int cyc = 0;
  always @(posedge i_clk_50m) cyc <= cyc + 1;

  int n_vec  = 0;
  int n_miss = 0;

  // Per-requester byte queues {last, data}: q* feeds the drivers, exp* is what
  // the UART must see from that requester, in order.
  logic [8:0] q0[$], q1[$], exp0[$], exp1[$];
  int         start_cyc[$];
  int         n_starts   = 0;
  bit         model_lg   = 1'b1;
  logic [1:0] cur_owner  = GRANT_NONE;
  bit         flood      = 1'b1;
  bit         noack_mode = 1'b0;
  bit         took0      = 1'b0;
  bit         took1      = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge i_clk_50m);
    #1;
  endtask

  task automatic push_byte(input int r, input logic [7:0] d, input bit last);
    if (r == 0) begin
      q0.push_back({last, d});
      exp0.push_back({last, d});
    end else begin
      q1.push_back({last, d});
      exp1.push_back({last, d});
    end
  endtask

  task automatic push_rand_pkt(input int r);
    int len;
    len = $urandom_range(1, 4);
    for (int i = 0; i < len; i++) push_byte(r, 8'($urandom), i == len - 1);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while (!(q0.size() == 0 && q1.size() == 0 && !req0_valid && !req1_valid &&
             o_grant == GRANT_NONE && !tx_busy) && n < budget) begin
      step();
      n++;
    end
    check(tag, 32'(n < budget), 1);
  endtask

  task automatic wait_starts(input string tag, input int target, input int budget);
    int n;
    n = 0;
    while (n_starts < target && n < budget) begin
      step();
      n++;
    end
    check(tag, 32'(n_starts >= target), 1);
  endtask

  // Scoreboard: each tx_start must carry the next byte of the granted
  // requester, packets never interleave, and ties follow round-robin.
  task automatic score_byte();
    logic [8:0] e;
    logic [1:0] want;
    n_starts++;
    start_cyc.push_back(cyc);
    if (cur_owner == GRANT_NONE) begin
      if (flood) begin
        if (exp0.size() > 0 && exp1.size() > 0) want = model_lg ? GRANT_REQ0 : GRANT_REQ1;
        else want = (exp0.size() > 0) ? GRANT_REQ0 : GRANT_REQ1;
        check("pkt_owner", 32'(o_grant), 32'(want));
      end
      cur_owner = o_grant;
    end else begin
      check("no_interleave", 32'(o_grant), 32'(cur_owner));
    end
    if (o_grant == GRANT_REQ0 && exp0.size() > 0) e = exp0.pop_front();
    else if (o_grant == GRANT_REQ1 && exp1.size() > 0) e = exp1.pop_front();
    else begin
      check("stray_start", 32'(tx_start), 0);
      return;
    end
    check("tx_data", 32'(tx_data), 32'(e[7:0]));
    if (e[8]) begin
      model_lg  = (o_grant == GRANT_REQ1);
      cur_owner = GRANT_NONE;
    end
  endtask

  initial begin : drv0
    req0_valid = 1'b0; req0_data = '0; req0_last = 1'b0;
    forever begin
      @(negedge i_clk_50m);
      if (!rst_n) begin
        req0_valid = 1'b0;
        took0 = 1'b0;
      end else begin
        if (took0) req0_valid = 1'b0;
        if (!req0_valid && q0.size() > 0) begin
          {req0_last, req0_data} = q0.pop_front();
          req0_valid = 1'b1;
        end
        #1 took0 = req0_valid && req0_ready;
      end
    end
  end

  initial begin : drv1
    req1_valid = 1'b0; req1_data = '0; req1_last = 1'b0;
    forever begin
      @(negedge i_clk_50m);
      if (!rst_n) begin
        req1_valid = 1'b0;
        took1 = 1'b0;
      end else begin
        if (took1) req1_valid = 1'b0;
        if (!req1_valid && q1.size() > 0) begin
          {req1_last, req1_data} = q1.pop_front();
          req1_valid = 1'b1;
        end
        #1 took1 = req1_valid && req1_ready;
      end
    end
  end

  // UART model: busy rises the cycle after tx_start and stays high BUSY_LEN cycles.
  initial begin : uart_model
    tx_busy = 1'b0;
    forever begin
      @(negedge i_clk_50m);
      if (rst_n && tx_start) begin
        score_byte();
        if (!noack_mode) begin
          @(posedge i_clk_50m);
          #1;
          if (rst_n) begin
            tx_busy = 1'b1;
            for (int k = 0; k < BUSY_LEN && rst_n; k++) @(posedge i_clk_50m);
            #1 tx_busy = 1'b0;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish by cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int t0, sc, s, a, n;
    logic [1:0] first;

    rst_n = 1'b0;
    repeat (3) step();
    check("rst_grant",    32'(o_grant),     0);
    check("rst_tx_start", 32'(tx_start),    0);
    check("rst_tx_data",  32'(tx_data),     0);
    check("rst_abort",    32'(o_abort),     0);
    check("rst_err",      32'(o_err_noack), 0);
    check("rst_ready0",   32'(req0_ready),  0);
    check("rst_ready1",   32'(req1_ready),  0);
    rst_n = 1'b1;
    step();
    check("post_rst_grant", 32'(o_grant), 0);

    // Tie straight out of reset, then a repeated tie.
    for (int rep = 0; rep < 2; rep++) begin
      first = model_lg ? GRANT_REQ0 : GRANT_REQ1;
      push_byte(0, 8'hC0 + 8'(rep), 1'b0); push_byte(0, 8'hC8 + 8'(rep), 1'b1);
      push_byte(1, 8'hD0 + 8'(rep), 1'b0); push_byte(1, 8'hD8 + 8'(rep), 1'b1);
      step();
      check("tie_first_grant", 32'(o_grant), 32'(first));
      wait_idle("tie_idle", 400);
    end

    // Single 3-byte packet: grant at N+1, first tx_start at N+2.
    push_byte(0, 8'h41, 1'b0); push_byte(0, 8'h42, 1'b0); push_byte(0, 8'h43, 1'b1);
    t0 = cyc;
    sc = n_starts;
    check("single_grant_n", 32'(o_grant), 0);
    step();
    check("single_grant_n1", 32'(o_grant),    32'(GRANT_REQ0));
    check("single_ready_n1", 32'(req0_ready), 1);
    check("single_start_n1", 32'(tx_start),   0);
    step();
    check("single_start_n2", 32'(tx_start), 1);
    check("single_data_n2",  32'(tx_data),  32'h41);
    wait_starts("single_starts", sc + 3, 200);
    check("single_first_start_cyc", 32'(start_cyc[sc]), 32'(t0 + 2));
    wait_idle("single_idle", 200);
    check("single_grant_end", 32'(o_grant), 0);
    check("single_all_sent", 32'(exp0.size()), 0);

    // No interleave: req1 arrives during req0's second byte.
    for (int i = 0; i < 4; i++) push_byte(0, 8'hA0 + 8'(i), i == 3);
    sc = n_starts;
    wait_starts("ni_second_byte", sc + 2, 200);
    push_byte(1, 8'hB0, 1'b0); push_byte(1, 8'hB1, 1'b1);
    n = 0;
    while (o_grant == GRANT_REQ0 && n < 200) begin
      check("ni_ready1_low", 32'(req1_ready), 0);
      step();
      n++;
    end
    check("ni_req0_bytes_done", 32'(n_starts), 32'(sc + 4));
    check("ni_idle_gap", 32'(o_grant), 0);
    step();
    check("ni_req1_granted", 32'(o_grant), 32'(GRANT_REQ1));
    wait_idle("ni_idle", 400);

    // Timeout: one non-last byte, then valid stays low; req1 waits.
    push_byte(0, 8'h10, 1'b0);
    sc = n_starts;
    wait_starts("to_start", sc + 1, 100);
    s = start_cyc[sc];
    push_byte(1, 8'h55, 1'b1);
    n = 0;
    while (!o_abort && n < 400) begin
      step();
      n++;
    end
    a = cyc;
    check("to_abort_seen", 32'(o_abort), 1);
    // start -> busy high (1) -> WAIT_LO -> busy low (BUSY_LEN+1) -> LOAD, then PKT_TO cycles
    check("to_abort_latency", 32'(a - s), 32'(2 + BUSY_LEN + PKT_TO));
    check("to_grant_cleared", 32'(o_grant), 0);
    cur_owner = GRANT_NONE;
    model_lg  = 1'b0;
    step();
    check("to_abort_one_cycle", 32'(o_abort), 0);
    check("to_req1_granted",    32'(o_grant), 32'(GRANT_REQ1));
    wait_idle("to_idle", 200);
    check("to_all_sent", 32'(exp1.size()), 0);

    // No-ack: busy never rises; flag sets after ACK_WAIT silent cycles and sticks.
    noack_mode = 1'b1;
    push_byte(1, 8'h61, 1'b0); push_byte(1, 8'h62, 1'b1);
    sc = n_starts;
    wait_starts("noack_start", sc + 1, 100);
    s = start_cyc[sc];
    while (cyc < s + ACK_WAIT) step();
    check("noack_err_before", 32'(o_err_noack), 0);
    step();
    check("noack_err_set", 32'(o_err_noack), 1);
    wait_idle("noack_idle", 200);
    check("noack_err_sticky", 32'(o_err_noack), 1);
    check("noack_all_sent", 32'(exp1.size()), 0);
    noack_mode = 1'b0;

    // Reset during WAIT_LO of byte 2.
    for (int i = 0; i < 3; i++) push_byte(0, 8'h71 + 8'(i), i == 2);
    sc = n_starts;
    wait_starts("mr_second_byte", sc + 2, 200);
    repeat (3) step();
    rst_n = 1'b0;
    q0.delete(); exp0.delete();
    cur_owner = GRANT_NONE;
    model_lg  = 1'b1;
    #1;
    check("mr_grant",    32'(o_grant),     0);
    check("mr_tx_data",  32'(tx_data),     0);
    check("mr_err",      32'(o_err_noack), 0);
    check("mr_tx_start", 32'(tx_start),    0);
    check("mr_ready0",   32'(req0_ready),  0);
    repeat (2) step();
    rst_n = 1'b1;
    repeat (2) step();
    push_byte(1, 8'h81, 1'b1);
    step();
    check("mr_req1_granted", 32'(o_grant), 32'(GRANT_REQ1));
    wait_idle("mr_idle", 200);
    check("mr_all_sent", 32'(exp1.size()), 0);

    // Random flood: both queues loaded at once, grants must alternate.
    for (int i = 0; i < 6; i++) begin
      push_rand_pkt(0);
      push_rand_pkt(1);
    end
    wait_idle("flood_idle", 3000);
    check("flood_all_sent", 32'(exp0.size() + exp1.size()), 0);

    // Random packets with random gaps: ordering and integrity only.
    flood = 1'b0;
    for (int i = 0; i < 12; i++) begin
      push_rand_pkt(int'($urandom_range(0, 1)));
      n = $urandom_range(0, 20);
      repeat (n) step();
    end
    wait_idle("gap_idle", 3000);
    check("gap_all_sent", 32'(exp0.size() + exp1.size()), 0);
    check("final_abort", 32'(o_abort), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
